// File: rtl/input_cond_pkg.sv
// Shared types and sizing helpers for the input conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package input_cond_pkg;

   // Debounce states. Level is high in STABLE_HI and DEB_LO.
   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      DEB_HI    = 2'd1,
      STABLE_HI = 2'd2,
      DEB_LO    = 2'd3
   } deb_state_t;

   // Bits needed to hold values 0..limit. Never less than 1.
   function automatic int cnt_width(input int limit);
      int w;
      w = $clog2(limit + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button: 2-flop synchroniser, debounce FSM, press/release pulse registers.
// Latency: 2 clk sync + DEBOUNCE_TICKS sample ticks to an accepted edge.
// Backpressure: none; the raw input is sampled every clk. INPUT_COND_AUTOREPEAT_EN adds hold-to-repeat.
module btn_debounce_channel
   import input_cond_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 4,
   parameter int REPEAT_DELAY   = 32,
   parameter int REPEAT_PERIOD  = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic sample_en,
   input  logic btn_raw,
   output logic level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int             CW       = cnt_width(DEBOUNCE_TICKS);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_TICKS);

   logic          sync_meta;
   logic          s;
   deb_state_t    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          press_nxt;
   logic          release_nxt;
   logic          repeat_hit;

   // Two-flop synchroniser, runs every clk regardless of the sample tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= 1'b0;
         s         <= 1'b0;
      end else begin
         sync_meta <= btn_raw;
         s         <= sync_meta;
      end
   end

   // State, counter and registered outputs; pulses self-clear every clk.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= STABLE_LO;
         cnt           <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         level         <= (state_nxt == STABLE_HI) || (state_nxt == DEB_LO);
         press_pulse   <= press_nxt | repeat_hit;
         release_pulse <= release_nxt;
      end
   end

   // Next-state logic; only moves on sample ticks. A glitch back to the
   // current stable level drops the count without any pulse.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      if (sample_en) begin
         case (state)
            STABLE_LO: begin
               if (s) begin
                  if (DEBOUNCE_TICKS == 1) begin
                     state_nxt = STABLE_HI;
                     cnt_nxt   = '0;
                     press_nxt = 1'b1;
                  end else begin
                     state_nxt = DEB_HI;
                     cnt_nxt   = CW'(1);
                  end
               end
            end
            DEB_HI: begin
               if (!s) begin
                  state_nxt = STABLE_LO;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nxt = STABLE_HI;
                  cnt_nxt   = '0;
                  press_nxt = 1'b1;
               end else if (cnt != CNT_MAX) begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            STABLE_HI: begin
               if (!s) begin
                  if (DEBOUNCE_TICKS == 1) begin
                     state_nxt   = STABLE_LO;
                     cnt_nxt     = '0;
                     release_nxt = 1'b1;
                  end else begin
                     state_nxt = DEB_LO;
                     cnt_nxt   = CW'(1);
                  end
               end
            end
            DEB_LO: begin
               if (s) begin
                  state_nxt = STABLE_HI;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nxt   = STABLE_LO;
                  cnt_nxt     = '0;
                  release_nxt = 1'b1;
               end else if (cnt != CNT_MAX) begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            default: begin
               state_nxt = STABLE_LO;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

`ifdef INPUT_COND_AUTOREPEAT_EN
   localparam int            HW          = cnt_width(REPEAT_DELAY);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

   logic [HW-1:0] hold, hold_nxt;

   // Hold counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold <= '0;
      end else begin
         hold <= hold_nxt;
      end
   end

   // Counts ticks spent in STABLE_HI; reloading after a hit makes later
   // repeats come every REPEAT_PERIOD ticks. Any other state clears it.
   always_comb begin
      hold_nxt   = '0;
      repeat_hit = 1'b0;
      if (state == STABLE_HI) begin
         if (!sample_en) begin
            hold_nxt = hold;
         end else if (s) begin
            if (hold == HOLD_LAST) begin
               hold_nxt   = HOLD_RELOAD;
               repeat_hit = 1'b1;
            end else begin
               hold_nxt = hold + HW'(1);
            end
         end
      end
   end
`else
   logic unused_repeat_cfg;

   // Without auto-repeat there is exactly one press pulse per accepted press.
   assign repeat_hit        = 1'b0;
   assign unused_repeat_cfg = (REPEAT_DELAY > 0) && (REPEAT_PERIOD > 0);
`endif

endmodule

// File: rtl/input_conditioner.sv
// Board-pin front end: synchronised switches, debounced buttons with press/release pulses.
// Latency: switches 2 clk; buttons 2 clk + DEBOUNCE_TICKS sample ticks.
// Backpressure: none; optional auto-repeat via INPUT_COND_AUTOREPEAT_EN.
module input_conditioner
   import input_cond_pkg::*;
#(
   parameter int N_SW           = 8,
   parameter int N_BTN          = 4,
   parameter int DEBOUNCE_TICKS = 4,
   parameter int REPEAT_DELAY   = 32,
   parameter int REPEAT_PERIOD  = 8
) (
   input  logic             clk_pi,
   input  logic             reset_pi,
   input  logic             sample_en_pi,
   input  logic [N_SW-1:0]  sw_pi,
   input  logic [N_BTN-1:0] btn_pi,
   output logic [N_SW-1:0]  sw_po,
   output logic [N_BTN-1:0] btn_level_po,
   output logic [N_BTN-1:0] btn_press_po,
   output logic [N_BTN-1:0] btn_release_po
);

   logic [N_SW-1:0] sw_meta;

   // Switch synchroniser; the second stage drives sw_po directly.
   always_ff @(posedge clk_pi) begin
      if (reset_pi) begin
         sw_meta <= '0;
         sw_po   <= '0;
      end else begin
         sw_meta <= sw_pi;
         sw_po   <= sw_meta;
      end
   end

   // One independent debounce channel per button.
   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce_channel #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_chan (
         .clk           (clk_pi),
         .reset         (reset_pi),
         .sample_en     (sample_en_pi),
         .btn_raw       (btn_pi[i]),
         .level         (btn_level_po[i]),
         .press_pulse   (btn_press_po[i]),
         .release_pulse (btn_release_po[i])
      );
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed vector table, corner-case sequences,
// then random stimulus against a tick-counting reference model.
module tb_input_conditioner;

   localparam int DT = 4;
   localparam int RD = 32;
   localparam int RP = 8;
`ifdef INPUT_COND_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
   localparam int HOLD_PRESS_CYCLES = 6;
`else
   localparam bit AR = 1'b0;
   localparam int HOLD_PRESS_CYCLES = 1;
`endif

   logic       clk = 1'b0;
   logic       reset_pi = 1'b1;
   logic       sample_en_pi = 1'b0;
   logic [7:0] sw_pi = '0;
   logic [3:0] btn_pi = '0;
   logic [7:0] sw_po;
   logic [3:0] btn_level_po, btn_press_po, btn_release_po;

   always #5 clk = ~clk;

   input_conditioner dut (
      .clk_pi         (clk),
      .reset_pi       (reset_pi),
      .sample_en_pi   (sample_en_pi),
      .sw_pi          (sw_pi),
      .btn_pi         (btn_pi),
      .sw_po          (sw_po),
      .btn_level_po   (btn_level_po),
      .btn_press_po   (btn_press_po),
      .btn_release_po (btn_release_po)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pin values age through two stages; each tick counts
   // how many consecutive ticks the synced value has disagreed with the
   // accepted level and flips the level once that reaches DT.
   logic [7:0] m_sw1, m_sw_out;
   logic [3:0] m_b1, m_b2, m_lvl, m_prs, m_rel;
   int         m_run [4];
   int         m_hold[4];

   task automatic model_update(input logic rst, input logic se, input logic [7:0] sw,
                               input logic [3:0] btn);
      if (rst) begin
         m_sw1 = '0; m_sw_out = '0; m_b1 = '0; m_b2 = '0;
         m_lvl = '0; m_prs = '0; m_rel = '0;
         for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_hold[i] = 0; end
      end else begin
         m_prs = '0;
         m_rel = '0;
         if (se) begin
            for (int i = 0; i < 4; i++) begin
               if (m_b2[i] != m_lvl[i]) begin
                  m_hold[i] = 0;
                  m_run[i]++;
                  if (m_run[i] >= DT) begin
                     m_run[i] = 0;
                     m_lvl[i] = ~m_lvl[i];
                     if (m_lvl[i]) m_prs[i] = 1'b1;
                     else          m_rel[i] = 1'b1;
                  end
               end else if (m_run[i] > 0) begin
                  m_run[i]  = 0;
                  m_hold[i] = 0;
               end else if (AR && m_lvl[i]) begin
                  m_hold[i]++;
                  if (m_hold[i] >= RD && (m_hold[i] - RD) % RP == 0) m_prs[i] = 1'b1;
               end
            end
         end
         m_sw_out = m_sw1;
         m_sw1    = sw;
         m_b2     = m_b1;
         m_b1     = btn;
      end
   endtask

   task automatic step(input logic rst, input logic se, input logic [7:0] sw, input logic [3:0] btn);
      reset_pi     = rst;
      sample_en_pi = se;
      sw_pi        = sw;
      btn_pi       = btn;
      @(posedge clk);
      model_update(rst, se, sw, btn);
      #1;
   endtask

   task automatic cmp_model(input string tag);
      check({tag, ".sw"},      32'(sw_po),          32'(m_sw_out));
      check({tag, ".level"},   32'(btn_level_po),   32'(m_lvl));
      check({tag, ".press"},   32'(btn_press_po),   32'(m_prs));
      check({tag, ".release"}, 32'(btn_release_po), 32'(m_rel));
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 8'h00, 4'h0);
      step(1'b1, 1'b0, 8'h00, 4'h0);
   endtask

   typedef struct {
      logic       rst;
      logic       se;
      logic [7:0] sw;
      logic [3:0] btn;
      logic [7:0] e_sw;
      logic [3:0] e_lvl;
      logic [3:0] e_prs;
      logic [3:0] e_rel;
   } vec_t;

   function automatic vec_t row(input logic rst, input logic se, input logic [7:0] sw,
                                input logic [3:0] btn, input logic [7:0] e_sw,
                                input logic [3:0] e_lvl, input logic [3:0] e_prs,
                                input logic [3:0] e_rel);
      vec_t v;
      v.rst = rst; v.se = se; v.sw = sw; v.btn = btn;
      v.e_sw = e_sw; v.e_lvl = e_lvl; v.e_prs = e_prs; v.e_rel = e_rel;
      return v;
   endfunction

   vec_t tbl[18];

   initial begin
      int np, nr, pc, rc;
      logic [3:0] pv, rv, b;
      logic se;

      // Reset with all inputs high, switch latency, clean press/release of BTN[1].
      tbl[0]  = row(1'b1, 1'b1, 8'hFF, 4'hF, 8'h00, 4'h0, 4'h0, 4'h0);
      tbl[1]  = row(1'b1, 1'b1, 8'hFF, 4'hF, 8'h00, 4'h0, 4'h0, 4'h0);
      tbl[2]  = row(1'b0, 1'b0, 8'hFF, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0);
      tbl[3]  = row(1'b0, 1'b0, 8'hFF, 4'h0, 8'hFF, 4'h0, 4'h0, 4'h0);
      tbl[4]  = row(1'b0, 1'b1, 8'hFF, 4'h2, 8'hFF, 4'h0, 4'h0, 4'h0);
      tbl[5]  = row(1'b0, 1'b1, 8'hFF, 4'h2, 8'hFF, 4'h0, 4'h0, 4'h0);
      tbl[6]  = row(1'b0, 1'b1, 8'hFF, 4'h2, 8'hFF, 4'h0, 4'h0, 4'h0);
      tbl[7]  = row(1'b0, 1'b1, 8'hFF, 4'h2, 8'hFF, 4'h0, 4'h0, 4'h0);
      tbl[8]  = row(1'b0, 1'b1, 8'hFF, 4'h2, 8'hFF, 4'h0, 4'h0, 4'h0);
      tbl[9]  = row(1'b0, 1'b1, 8'hFF, 4'h2, 8'hFF, 4'h2, 4'h2, 4'h0);
      tbl[10] = row(1'b0, 1'b1, 8'hA5, 4'h2, 8'hFF, 4'h2, 4'h0, 4'h0);
      tbl[11] = row(1'b0, 1'b1, 8'hA5, 4'h0, 8'hA5, 4'h2, 4'h0, 4'h0);
      tbl[12] = row(1'b0, 1'b1, 8'hA5, 4'h0, 8'hA5, 4'h2, 4'h0, 4'h0);
      tbl[13] = row(1'b0, 1'b1, 8'hA5, 4'h0, 8'hA5, 4'h2, 4'h0, 4'h0);
      tbl[14] = row(1'b0, 1'b1, 8'hA5, 4'h0, 8'hA5, 4'h2, 4'h0, 4'h0);
      tbl[15] = row(1'b0, 1'b1, 8'hA5, 4'h0, 8'hA5, 4'h2, 4'h0, 4'h0);
      tbl[16] = row(1'b0, 1'b1, 8'hA5, 4'h0, 8'hA5, 4'h0, 4'h0, 4'h2);
      tbl[17] = row(1'b0, 1'b1, 8'hA5, 4'h0, 8'hA5, 4'h0, 4'h0, 4'h0);

      for (int r = 0; r < 18; r++) begin
         step(tbl[r].rst, tbl[r].se, tbl[r].sw, tbl[r].btn);
         check($sformatf("tbl%0d.sw", r),      32'(sw_po),          32'(tbl[r].e_sw));
         check($sformatf("tbl%0d.level", r),   32'(btn_level_po),   32'(tbl[r].e_lvl));
         check($sformatf("tbl%0d.press", r),   32'(btn_press_po),   32'(tbl[r].e_prs));
         check($sformatf("tbl%0d.release", r), 32'(btn_release_po), 32'(tbl[r].e_rel));
      end

      // Bounce on BTN[0]: 2 high, 1 low, then high; one press on 4th tick of final run.
      do_reset();
      np = 0; nr = 0; pc = -1;
      for (int c = 0; c < 12; c++) begin
         b = (c == 2) ? 4'h0 : 4'h1;
         step(1'b0, 1'b1, 8'h00, b);
         cmp_model("bounce");
         if (btn_press_po != 4'h0) begin np++; pc = c; end
         if (btn_release_po != 4'h0) nr++;
      end
      check("bounce.press_count", 32'(np), 32'd1);
      check("bounce.press_cycle", 32'(pc), 32'd8);
      check("bounce.release_count", 32'(nr), 32'd0);
      check("bounce.level", 32'(btn_level_po), 32'h1);

      // BTN[3] and BTN[2] together with the tick held high, then held long, then released.
      do_reset();
      np = 0; nr = 0; rc = -1; rv = '0;
      for (int c = 0; c < 70; c++) begin
         step(1'b0, 1'b1, 8'h00, 4'hC);
         cmp_model("simul");
         if (c == 4) check("simul.before", 32'(btn_press_po), 32'h0);
         if (c == 5) check("simul.press",  32'(btn_press_po), 32'hC);
         if (c == 6) check("simul.width",  32'(btn_press_po), 32'h0);
         if (btn_press_po != 4'h0) np++;
      end
      check("hold.press_cycles", 32'(np), 32'(HOLD_PRESS_CYCLES));
      np = 0;
      for (int c = 70; c < 110; c++) begin
         step(1'b0, 1'b1, 8'h00, 4'h0);
         cmp_model("rel");
         if (btn_press_po != 4'h0) np++;
         if (btn_release_po != 4'h0) begin nr++; rc = c; rv = btn_release_po; end
      end
      check("rel.press_after", 32'(np), 32'd0);
      check("rel.count", 32'(nr), 32'd1);
      check("rel.cycle", 32'(rc), 32'd75);
      check("rel.value", 32'(rv), 32'hC);

      // Reset in the middle of a debounce on BTN[0].
      do_reset();
      np = 0; pc = -1; pv = '0;
      for (int c = 0; c < 16; c++) begin
         step((c == 5) ? 1'b1 : 1'b0, 1'b1, 8'h00, 4'h1);
         cmp_model("midrst");
         if (btn_press_po != 4'h0) begin
            np++;
            if (pc < 0) begin pc = c; pv = btn_press_po; end
         end
      end
      check("midrst.count", 32'(np), 32'd1);
      check("midrst.cycle", 32'(pc), 32'd11);
      check("midrst.value", 32'(pv), 32'h1);

      // Random buttons, ticks and occasional resets against the model.
      do_reset();
      b = '0;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 11) == 0) b[i] = ~b[i];
         if (((c / 500) % 2) == 0) se = ($urandom_range(0, 3) != 0);
         else                      se = ($urandom_range(0, 3) == 0);
         step(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0, se, 8'($urandom), b);
         cmp_model("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage between the board pins (SW[7:0], BTN[3:0]) and the processor core.
- Synchronises all switch and button inputs.
- Debounces the buttons using a slow sample tick.
- Produces clean levels plus single-clock press and release pulses for the core's reset and control logic, so raw bouncing buttons never reach the CPU.

Parameters:
- N_SW, 8, number of switch inputs
- N_BTN, 4, number of button inputs
- DEBOUNCE_TICKS, 4, consecutive sample ticks a new level must hold before it is accepted (legal range 1..255)
- REPEAT_DELAY, 32, ticks of continuous hold before the first auto-repeat pulse (used only with the optional feature)
- REPEAT_PERIOD, 8, ticks between subsequent auto-repeat pulses (used only with the optional feature)

Ports:
- clk_pi  in  1  system clock; the only clock
- reset_pi  in  1  synchronous, active-high reset
- sample_en_pi  in  1  one-clk-wide sample tick from a display_clkdiv instance
- sw_pi  in  N_SW  raw switches
- btn_pi  in  N_BTN  raw buttons
- sw_po  out  N_SW  synchronised switches
- btn_level_po  out  N_BTN  debounced button level
- btn_press_po  out  N_BTN  one-clk pulse on an accepted 0->1 transition (and on auto-repeat)
- btn_release_po  out  N_BTN  one-clk pulse on an accepted 1->0 transition

Behaviour:
- Synchronisers:
  - Every input passes through a 2-flop synchroniser clocked every clk, with no clock enable.
  - sw_po equals sw_pi delayed by exactly 2 clk.
  - The synchronised button bit is called s[i].
- Reset:
  - While reset_pi is high at a clk edge, all synchroniser flops, sw_po, btn_level_po, btn_press_po, btn_release_po, counters and FSMs go to 0 / STABLE_LO.
  - Reset asserted mid-count discards the count; no pulse is emitted.
- Per-button FSM, which advances only on clk edges where sample_en_pi=1:
  - STABLE_LO:
    - If s=1 and DEBOUNCE_TICKS=1, go to STABLE_HI.
    - Otherwise if s=1, go to DEB_HI with cnt=1.
    - Otherwise stay.
  - DEB_HI:
    - If s=0, go to STABLE_LO with cnt=0 (glitch rejected).
    - Else if cnt=DEBOUNCE_TICKS-1, go to STABLE_HI.
    - Else cnt+1.
  - STABLE_HI and DEB_LO: mirror images of the two states above.
- Outputs:
  - On entry to STABLE_HI: btn_level_po[i] becomes 1 and btn_press_po[i] is 1 in that same clk cycle only.
  - On entry to STABLE_LO from DEB_LO: btn_level_po[i] becomes 0 and btn_release_po[i] is pulsed likewise.
  - Pulses are registered and are never wider than 1 clk, even if sample_en_pi is held high continuously.
- Latency:
  - The press is accepted on the DEBOUNCE_TICKS-th tick at which s=1.
  - Minimum latency is 2 clk of synchronisation plus DEBOUNCE_TICKS ticks.
- Buttons are fully independent. Simultaneous transitions on several buttons produce simultaneous pulses.
- sample_en_pi=0 freezes all FSMs and counters. Synchronisers and pulse clearing keep running.
- Counter width is clog2(DEBOUNCE_TICKS+1). The counter saturates and never wraps.

Optional Feature:
- Macro: INPUT_COND_AUTOREPEAT_EN
- Defined:
  - In STABLE_HI a hold counter increments on each tick.
  - When it reaches REPEAT_DELAY, btn_press_po[i] pulses for 1 clk and the counter reloads so that further pulses occur every REPEAT_PERIOD ticks.
  - Leaving STABLE_HI clears the hold counter.
  - btn_level_po is unaffected by auto-repeat.
- Undefined:
  - No hold counter exists.
  - Exactly one press pulse is emitted per accepted press.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.

Decomposition:
- Package input_cond_pkg holds:
  - the typedef for the 2-bit debounce state enum (STABLE_LO, DEB_HI, STABLE_HI, DEB_LO);
  - a localparam function for counter width.
- Sub-module btn_debounce_channel:
  - one synchroniser, one FSM, one counter and the optional hold counter;
  - instantiated N_BTN times by generate.
- The switch synchronisers stay in the top module.

Test Plan:
- Reset: assert reset_pi for 2 clk with all inputs at 1 -> every output is 0 on the following edge; sw_po=8'hFF exactly 2 clk after deassertion.
- Clean press, DEBOUNCE_TICKS=4: BTN[1]=1 held -> btn_level_po=4'b0010 and btn_press_po[1] high for exactly 1 clk on the 4th sample tick after s[1] rises; release gives a btn_release_po[1] pulse symmetrically.
- Bounce: BTN[0] high for 2 ticks, low for 1 tick, high for 4 ticks -> exactly one press pulse, on the 4th tick of the final high run; no release pulse.
- Simultaneous: BTN[3] and BTN[2] rise on the same clk -> press pulses on both bits in the same cycle; sample_en_pi held high continuously -> each pulse is still 1 clk wide.
- Reset mid-debounce: BTN[0] high for 3 ticks, then reset_pi pulsed, then held high -> no pulse before reset; press occurs 4 ticks after s[0] is resampled high.
- With INPUT_COND_AUTOREPEAT_EN, REPEAT_DELAY=32, REPEAT_PERIOD=8: hold BTN[2] -> press at acceptance, then at +32 ticks, +40, +48; release stops the pulses. Without the macro -> a single pulse only.
